alu_op_sequencer: RTL

- Control-side driver for the 16-bit ALU. Accepts one instruction per valid/ready handshake.
- Checks the instruction's condition code against the ALU's registered flags, then drives FunSel/WF for one or two cycles and strobes register write-enable.
- Supports 32-bit "double" add as ADD low half then ADC high half, so carry chains through the ALU flag register.
- Sits between instruction decode and the ALU/register file.

---
 rtl/alu_pkg.sv | 53 +++++
 rtl/alu_cond_eval.sv | 27 ++
 rtl/alu_op_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU encodings for the control side.
// Holds FunSel codes, flag bit positions, condition codes, the sequencer
// state type and the latched-instruction record.
package alu_pkg;

   // ALU function select codes (bit 4 = 16-bit operation)
   localparam logic [4:0] FS_PASSA = 5'b10000;
   localparam logic [4:0] FS_ADD   = 5'b10100;
   localparam logic [4:0] FS_ADC   = 5'b10101;
   localparam logic [4:0] FS_AND   = 5'b10111;

   // Opcode that is allowed to form a double (two-pass) add
   localparam logic [3:0] OP_ADD = 4'b0100;

   // Bit positions inside the ALU flag vector {Z,C,N,O}
   localparam int FLG_Z = 3;
   localparam int FLG_C = 2;
   localparam int FLG_N = 1;
   localparam int FLG_O = 0;

   typedef enum logic [2:0] {
      COND_AL = 3'd0,
      COND_EQ = 3'd1,
      COND_NE = 3'd2,
      COND_CS = 3'd3,
      COND_CC = 3'd4,
      COND_MI = 3'd5,
      COND_PL = 3'd6,
      COND_VS = 3'd7
   } cond_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CHECK   = 3'd1,
      ST_EXEC_LO = 3'd2,
      ST_EXEC_HI = 3'd3,
      ST_DONE    = 3'd4
   } seq_state_e;

   typedef struct packed {
      logic [3:0] opcode;
      logic       wide;
      logic       dbl;
      cond_e      cond;
      logic       set_flags;
   } instr_t;

   // FunSel driven during the first (or only) execute cycle
   function automatic logic [4:0] exec_lo_funsel(input instr_t instr);
      return {instr.wide | instr.dbl, instr.opcode};
   endfunction

endpackage

// File: rtl/alu_cond_eval.sv
// alu_cond_eval: combinational condition-code check against ALU flags.
module alu_cond_eval
   import alu_pkg::*;
(
   input  logic [2:0] cond,
   input  logic [3:0] flags,
   output logic       pass
);

   // Decode the condition code into a single pass/fail bit
   always_comb begin
      // NOTE: default assignment first so no path through the case leaves pass unassigned (no latch).
      pass = 1'b1;
      case (cond_e'(cond))
         COND_AL: pass = 1'b1;
         COND_EQ: pass = flags[FLG_Z];
         COND_NE: pass = ~flags[FLG_Z];
         COND_CS: pass = flags[FLG_C];
         COND_CC: pass = ~flags[FLG_C];
         COND_MI: pass = flags[FLG_N];
         COND_PL: pass = ~flags[FLG_N];
         COND_VS: pass = flags[FLG_O];
         default: pass = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives ALU FunSel/WF and register write strobe for one
// instruction at a time, including a two-pass 32-bit add (ADD then ADC).
// All outputs are registered and decoded from next state, so no
// combinational path exists from InstrValid to FunSel/WF.
// Optional macro ALUSEQ_PERF_EN adds saturating ExecCount/SkipCount outputs.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned ILLEGAL_TRAP = 1
`ifdef ALUSEQ_PERF_EN
   ,
   parameter int unsigned PERF_CNT_W   = 16
`endif
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       InstrValid,
   output logic       InstrReady,
   input  logic [3:0] Opcode,
   input  logic       Wide,
   input  logic       Double,
   input  logic [2:0] Cond,
   input  logic       SetFlags,
   input  logic [3:0] FlagsIn,
   output logic [4:0] FunSel,
   output logic       WF,
   output logic       RegWE,
   output logic       HalfSel,
   output logic       Done,
   output logic       Skipped,
   output logic       Error
`ifdef ALUSEQ_PERF_EN
   ,
   output logic [PERF_CNT_W-1:0] ExecCount,
   output logic [PERF_CNT_W-1:0] SkipCount
`endif
);

   seq_state_e state_q, state_d;
   instr_t     instr_q, instr_d;
   logic       ready_q, ready_d;
   logic [4:0] funsel_q, funsel_d;
   logic       wf_q, wf_d;
   logic       regwe_q, regwe_d;
   logic       halfsel_q, halfsel_d;
   logic       done_q, done_d;
   logic       skipped_q, skipped_d;
   logic       error_q, error_d;

   logic       cond_pass;
   logic       illegal_dbl;

   alu_cond_eval u_cond_eval (
      .cond  (instr_q.cond),
      .flags (FlagsIn),
      .pass  (cond_pass)
   );

   // Only ADD may be split into ADD/ADC halves
   assign illegal_dbl = instr_q.dbl && (instr_q.opcode != OP_ADD);

   // Next-state and instruction-latch logic
   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      skipped_d = 1'b0;
      error_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (InstrValid) begin
               instr_d = '{opcode:    Opcode,
                           wide:      Wide,
                           dbl:       Double,
                           cond:      cond_e'(Cond),
                           set_flags: SetFlags};
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (illegal_dbl && (ILLEGAL_TRAP != 0)) begin
               error_d = 1'b1;
               state_d = ST_DONE;
            end else if (!cond_pass) begin
               skipped_d = 1'b1;
               state_d   = ST_DONE;
            end else begin
               // Untrapped illegal double degrades to a plain single op
               if (illegal_dbl) instr_d.dbl = 1'b0;
               state_d = ST_EXEC_LO;
            end
         end
         ST_EXEC_LO: state_d = instr_q.dbl ? ST_EXEC_HI : ST_DONE;
         ST_EXEC_HI: state_d = ST_DONE;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Output decode from next state so outputs register alongside the state
   always_comb begin
      ready_d   = (state_d == ST_IDLE);
      done_d    = (state_d == ST_DONE);
      funsel_d  = FS_PASSA;
      wf_d      = 1'b0;
      regwe_d   = 1'b0;
      halfsel_d = 1'b0;
      case (state_d)
         ST_EXEC_LO: begin
            funsel_d = exec_lo_funsel(instr_d);
            wf_d     = instr_d.set_flags | instr_d.dbl;
            regwe_d  = 1'b1;
         end
         ST_EXEC_HI: begin
            // ADC consumes the carry the ALU registered at the end of EXEC_LO
            funsel_d  = FS_ADC;
            wf_d      = instr_d.set_flags;
            regwe_d   = 1'b1;
            halfsel_d = 1'b1;
         end
         default: ;
      endcase
   end

   // State, latched instruction and registered outputs
   always_ff @(posedge Clock) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      if (Reset) begin
         state_q   <= ST_IDLE;
         instr_q   <= '0;
         ready_q   <= 1'b1;
         funsel_q  <= FS_PASSA;
         wf_q      <= 1'b0;
         regwe_q   <= 1'b0;
         halfsel_q <= 1'b0;
         done_q    <= 1'b0;
         skipped_q <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         ready_q   <= ready_d;
         funsel_q  <= funsel_d;
         wf_q      <= wf_d;
         regwe_q   <= regwe_d;
         halfsel_q <= halfsel_d;
         done_q    <= done_d;
         skipped_q <= skipped_d;
         error_q   <= error_d;
      end
   end

   assign InstrReady = ready_q;
   assign FunSel     = funsel_q;
   assign WF         = wf_q;
   assign RegWE      = regwe_q;
   assign HalfSel    = halfsel_q;
   assign Done       = done_q;
   assign Skipped    = skipped_q;
   assign Error      = error_q;

`ifdef ALUSEQ_PERF_EN
   logic [PERF_CNT_W-1:0] exec_cnt_q, exec_cnt_d;
   logic [PERF_CNT_W-1:0] skip_cnt_q, skip_cnt_d;
   localparam logic [PERF_CNT_W-1:0] CNT_ONE = {{(PERF_CNT_W-1){1'b0}}, 1'b1};

   // Saturating counters that step in the same cycle Done is raised
   always_comb begin
      exec_cnt_d = exec_cnt_q;
      skip_cnt_d = skip_cnt_q;
      if (done_d && !skipped_d && !error_d && (exec_cnt_q != '1))
         exec_cnt_d = exec_cnt_q + CNT_ONE;
      if (done_d && skipped_d && (skip_cnt_q != '1))
         skip_cnt_d = skip_cnt_q + CNT_ONE;
   end

   // Counter registers, cleared by Reset
   always_ff @(posedge Clock) begin
      if (Reset) begin
         exec_cnt_q <= '0;
         skip_cnt_q <= '0;
      end else begin
         exec_cnt_q <= exec_cnt_d;
         skip_cnt_q <= skip_cnt_d;
      end
   end

   assign ExecCount = exec_cnt_q;
   assign SkipCount = skip_cnt_q;
`endif

endmodule
